// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// load funct3 encodings and the access FSM state type.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: shifts the addressed lane of a 64-bit read
// word down to bit 0 and sign/zero-extends it according to funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  data = {56'd0, shifted[7:0]};
      F3_LHU:  data = {48'd0, shifted[15:0]};
      F3_LWU:  data = {32'd0, shifted[31:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller (IDLE/REQ/WAIT/DONE handshake FSM).
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
//
// Handshake: a request transfers on a cycle where dmem_req_valid and
// dmem_req_ready are both 1; the payload is held stable while valid is high
// and ready is low. A response is a single cycle with dmem_resp_valid=1 and is
// only accepted in WAIT.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_mem,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [63:0] addr_mem,
  input  logic [63:0] wdata_mem,
  input  logic [7:0]  mask_mem,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_resp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        stall_mem,
  output logic [63:0] load_data,
  output logic        access_done,
  output logic        timeout_err,
  output mem_state_e  state_dbg
);

  mem_state_e  state;
  logic [2:0]  funct3_q;
  logic [63:0] aligned;
  logic        access_req;
  logic        wd_hit;

  assign access_req = valid_mem & (re_mem | we_mem);
  assign state_dbg  = state;
  assign stall_mem  = ((state == ST_IDLE) & access_req) |
                      (state == ST_REQ) | (state == ST_WAIT);

  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .offset (dmem_addr[2:0]),
    .funct3 (funct3_q),
    .data   (aligned)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // Counts cycles spent in REQ+WAIT; hit on the last allowed cycle.
  assign wd_hit = (wd_cnt >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == ST_REQ || state == ST_WAIT) begin
      wd_cnt <= wd_cnt + CW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_hit = 1'b0;

  // The limit only matters when the watchdog is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_limit_unused
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      funct3_q       <= '0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wmask     <= '0;
      dmem_req_valid <= 1'b0;
      load_data      <= '0;
      access_done    <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_req) begin
            funct3_q       <= funct3_mem;
            dmem_we        <= we_mem;
            dmem_addr      <= addr_mem;
            dmem_wdata     <= wdata_mem;
            dmem_wmask     <= mask_mem;
            dmem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An accepted request wins over the watchdog on the same edge.
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= ST_WAIT;
          end else if (wd_hit) begin
            dmem_req_valid <= 1'b0;
            load_data      <= '0;
            timeout_err    <= 1'b1;
            access_done    <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (dmem_resp_valid) begin
            if (!dmem_we) load_data <= aligned;
            access_done <= 1'b1;
            state       <= ST_DONE;
          end else if (wd_hit) begin
            load_data   <= '0;
            timeout_err <= 1'b1;
            access_done <= 1'b1;
            state       <= ST_DONE;
          end
        end
        default: begin
          access_done <= 1'b0;
          timeout_err <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads with lane extension, a stalled
// store, load+store collision, mid-transaction reset and watchdog behaviour.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_mem, re_mem, we_mem;
  logic [2:0]  funct3_mem;
  logic [63:0] addr_mem, wdata_mem;
  logic [7:0]  mask_mem;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_rdata;
  logic        stall_mem;
  logic [63:0] load_data;
  logic        access_done, timeout_err;
  mem_state_e  state_dbg;

  int          checks;
  int          errors;
  int          hs;
  logic [63:0] last_load;

  mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_mem       (valid_mem),
    .re_mem          (re_mem),
    .we_mem          (we_mem),
    .funct3_mem      (funct3_mem),
    .addr_mem        (addr_mem),
    .wdata_mem       (wdata_mem),
    .mask_mem        (mask_mem),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wmask      (dmem_wmask),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .stall_mem       (stall_mem),
    .load_data       (load_data),
    .access_done     (access_done),
    .timeout_err     (timeout_err),
    .state_dbg       (state_dbg)
  );

  // Clock / run-time guard
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_mem = 1'b0; re_mem = 1'b0; we_mem = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
  endtask

  // Zero-wait load: stall in IDLE, REQ, WAIT; released in DONE.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] rdata, input logic [63:0] exp);
    valid_mem = 1'b1; re_mem = 1'b1; we_mem = 1'b0; funct3_mem = f3; addr_mem = addr;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
    #1;
    chk({tag, "_stall_c1"}, stall_mem, 1'b1);
    chk({tag, "_reqv_idle"}, dmem_req_valid, 1'b0);
    tick();
    chk({tag, "_state_req"}, state_dbg, ST_REQ);
    chk({tag, "_stall_c2"}, stall_mem, 1'b1);
    chk({tag, "_reqv"}, dmem_req_valid, 1'b1);
    chk({tag, "_addr"}, dmem_addr, addr);
    chk({tag, "_we"}, dmem_we, 1'b0);
    tick();
    dmem_resp_valid = 1'b1; dmem_rdata = rdata;
    #1;
    chk({tag, "_state_wait"}, state_dbg, ST_WAIT);
    chk({tag, "_stall_c3"}, stall_mem, 1'b1);
    chk({tag, "_reqv_wait"}, dmem_req_valid, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk({tag, "_stall_c4"}, stall_mem, 1'b0);
    chk({tag, "_done"}, access_done, 1'b1);
    chk({tag, "_data"}, load_data, exp);
    chk({tag, "_tmo"}, timeout_err, 1'b0);
    last_load = exp;
    tick();
    chk({tag, "_done_pulse"}, access_done, 1'b0);
    chk({tag, "_back_idle"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    checks = 0; errors = 0; hs = 0; last_load = '0;
    rst = 1'b0;
    idle_inputs();
    funct3_mem = 3'b000; addr_mem = '0; wdata_mem = '0; mask_mem = '0; dmem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_stall", stall_mem, 1'b0);
    chk("rst_reqv", dmem_req_valid, 1'b0);
    chk("rst_done", access_done, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_load", load_data, 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    rst = 1'b1;
    tick(); tick();
    chk("idle_stall", stall_mem, 1'b0);

    // Loads across widths, offsets and signedness
    do_load("lb",  64'h1003, F3_LB,  64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    do_load("lwu", 64'h1004, F3_LWU, 64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF);
    do_load("lh",  64'h1006, F3_LH,  64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001);
    do_load("lbu", 64'h1007, F3_LBU, 64'hF0_00_0000_0000_0000, 64'h00000000_000000F0);
    do_load("lw",  64'h1000, F3_LW,  64'h12345678_7FFFFFFF, 64'h00000000_7FFFFFFF);
    do_load("lhu", 64'h1002, F3_LHU, 64'h00000000_ABCD0000, 64'h00000000_0000ABCD);
    do_load("ld",  64'h1008, F3_LD,  64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

    // SD with ready low for 5 cycles; upstream inputs change underneath
    valid_mem = 1'b1; re_mem = 1'b0; we_mem = 1'b1; funct3_mem = F3_LD;
    addr_mem = 64'h2000; wdata_mem = 64'h11223344_55667788; mask_mem = 8'hFF;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    tick();
    addr_mem = 64'h0; wdata_mem = 64'hBAD0BAD0_BAD0BAD0; mask_mem = 8'h01;
    for (int i = 0; i < 5; i++) begin
      dmem_resp_valid = (i == 2);
      #1;
      chk("sd_state", state_dbg, ST_REQ);
      chk("sd_reqv", dmem_req_valid, 1'b1);
      chk("sd_addr", dmem_addr, 64'h2000);
      chk("sd_wdata", dmem_wdata, 64'h11223344_55667788);
      chk("sd_mask", dmem_wmask, 8'hFF);
      chk("sd_we", dmem_we, 1'b1);
      chk("sd_stall", stall_mem, 1'b1);
      if (dmem_req_valid && dmem_req_ready) hs++;
      tick();
    end
    dmem_resp_valid = 1'b0; dmem_req_ready = 1'b1;
    #1;
    if (dmem_req_valid && dmem_req_ready) hs++;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    if (dmem_req_valid && dmem_req_ready) hs++;
    chk("sd_handshakes", hs, 1);
    chk("sd_state_wait", state_dbg, ST_WAIT);
    dmem_resp_valid = 1'b1; dmem_rdata = 64'hFFFF0000_FFFF0000;
    tick();
    idle_inputs();
    #1;
    chk("sd_done", access_done, 1'b1);
    chk("sd_stall_done", stall_mem, 1'b0);
    chk("sd_load_kept", load_data, last_load);
    tick();

    // re and we both set: performed as a store
    valid_mem = 1'b1; re_mem = 1'b1; we_mem = 1'b1; funct3_mem = F3_LB;
    addr_mem = 64'h3001; wdata_mem = 64'h0000_0000_0000_AA00; mask_mem = 8'h02;
    dmem_req_ready = 1'b1;
    tick();
    chk("rw_we", dmem_we, 1'b1);
    chk("rw_mask", dmem_wmask, 8'h02);
    tick();
    dmem_resp_valid = 1'b1; dmem_rdata = 64'h00000000_0000FF00;
    tick();
    idle_inputs();
    #1;
    chk("rw_done", access_done, 1'b1);
    chk("rw_load_kept", load_data, last_load);
    tick();

    // Reset asserted in WAIT, then a late response
    valid_mem = 1'b1; re_mem = 1'b1; we_mem = 1'b0; funct3_mem = F3_LD;
    addr_mem = 64'h4000; dmem_req_ready = 1'b1;
    tick(); tick();
    chk("mr_in_wait", state_dbg, ST_WAIT);
    #2;
    rst = 1'b0; valid_mem = 1'b0; dmem_req_ready = 1'b0;
    #1;
    chk("mr_async_state", state_dbg, ST_IDLE);
    chk("mr_async_load", load_data, 64'd0);
    #1;
    rst = 1'b1;
    dmem_resp_valid = 1'b1; dmem_rdata = 64'h5555AAAA_5555AAAA;
    tick();
    dmem_resp_valid = 1'b0;
    #1;
    chk("mr_state", state_dbg, ST_IDLE);
    chk("mr_done", access_done, 1'b0);
    chk("mr_reqv", dmem_req_valid, 1'b0);
    chk("mr_stall", stall_mem, 1'b0);
    chk("mr_load", load_data, 64'd0);
    chk("mr_addr", dmem_addr, 64'd0);
    chk("mr_tmo", timeout_err, 1'b0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Watchdog of 8 cycles: REQ at cycle 1, timeout pulse at cycle 9
    valid_mem = 1'b1; re_mem = 1'b1; we_mem = 1'b0; funct3_mem = F3_LD;
    addr_mem = 64'h5000; dmem_req_ready = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("wd_no_tmo", timeout_err, 1'b0);
      chk("wd_stall", stall_mem, 1'b1);
      tick();
    end
    idle_inputs();
    #1;
    chk("wd_tmo", timeout_err, 1'b1);
    chk("wd_done", access_done, 1'b1);
    chk("wd_stall_rel", stall_mem, 1'b0);
    chk("wd_load", load_data, 64'd0);
    tick();
    chk("wd_tmo_pulse", timeout_err, 1'b0);
    chk("wd_idle", state_dbg, ST_IDLE);
`else
    // No watchdog: WAIT holds indefinitely until the response
    valid_mem = 1'b1; re_mem = 1'b1; we_mem = 1'b0; funct3_mem = F3_LW;
    addr_mem = 64'h5004; dmem_req_ready = 1'b1;
    tick(); tick();
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("nw_state", state_dbg, ST_WAIT);
      chk("nw_tmo", timeout_err, 1'b0);
      tick();
    end
    dmem_resp_valid = 1'b1; dmem_rdata = 64'h80000000_00000000;
    tick();
    idle_inputs();
    #1;
    chk("nw_done", access_done, 1'b1);
    chk("nw_data", load_data, 64'hFFFFFFFF_80000000);
    chk("nw_tmo_done", timeout_err, 1'b0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
